control_unit: RTL and testbench

//   Instruction-side controller of the accumulator CPU: fetches 16-bit instructions from program memory and decodes them.

---
 rtl/control_unit.sv | 151 +++++++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction-side controller of the accumulator CPU: fetches 16-bit instructions, sequences a
// FETCH/DECODE/EXEC(/EXEC2) cycle and drives datapath and data-memory controls.
module control_unit #(
    parameter int unsigned NBITS_I   = 16,
    parameter int unsigned NBITS_OPC = 5,
    parameter int unsigned NBITS_O   = 11,
    parameter int unsigned NBITS_CYC = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NBITS_I-1:0]   i_Instruction,
    output logic [NBITS_O-1:0]   o_PmAddr,
    output logic [NBITS_O-1:0]   o_DmAddr,
    output logic [NBITS_O-1:0]   o_Operand,
    output logic [1:0]           o_SelA,
    output logic                 o_SelB,
    output logic                 o_WrAcc,
    output logic                 o_Op,
    output logic                 o_RdRam,
    output logic                 o_WrRam,
    output logic                 o_halt,
    output logic [NBITS_CYC-1:0] o_cycles
);

    localparam logic [NBITS_OPC-1:0] OpcHlt  = NBITS_OPC'(0);
    localparam logic [NBITS_OPC-1:0] OpcSto  = NBITS_OPC'(1);
    localparam logic [NBITS_OPC-1:0] OpcLd   = NBITS_OPC'(2);
    localparam logic [NBITS_OPC-1:0] OpcLdi  = NBITS_OPC'(3);
    localparam logic [NBITS_OPC-1:0] OpcAdd  = NBITS_OPC'(4);
    localparam logic [NBITS_OPC-1:0] OpcAddi = NBITS_OPC'(5);
    localparam logic [NBITS_OPC-1:0] OpcSub  = NBITS_OPC'(6);
    localparam logic [NBITS_OPC-1:0] OpcSubi = NBITS_OPC'(7);

    localparam logic [1:0] SelMem = 2'b00;
    localparam logic [1:0] SelImm = 2'b01;
    localparam logic [1:0] SelAlu = 2'b10;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StExec2,
        StHalt
    } state_e;

    state_e               state_q, state_d;
    logic [NBITS_O-1:0]   pc_q, pc_d;
    logic [NBITS_I-1:0]   ir_q, ir_d;
    logic [NBITS_CYC-1:0] cycles_q, cycles_d;

    logic [NBITS_OPC-1:0] opcode;
    logic                 active;
    logic                 mem_op;
    logic [1:0]           sel_a;
    logic                 sel_b;
    logic                 wr_acc;
    logic                 alu_op;
    logic                 rd_ram;
    logic                 wr_ram;

    assign opcode = ir_q[NBITS_I-1 -: NBITS_OPC];
    assign active = i_enable & ~i_reset;
    assign mem_op = (opcode == OpcLd) || (opcode == OpcAdd) || (opcode == OpcSub);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cycles_d = cycles_q;
        sel_a    = SelMem;
        sel_b    = 1'b0;
        wr_acc   = 1'b0;
        alu_op   = 1'b0;
        rd_ram   = 1'b0;
        wr_ram   = 1'b0;

        if (active) begin
            if (state_q != StHalt && cycles_q != '1) begin
                cycles_d = cycles_q + NBITS_CYC'(1);
            end
            unique case (state_q)
                StFetch: state_d = StDecode;
                StDecode: begin
                    ir_d    = i_Instruction;
                    state_d = StExec;
                end
                StExec: begin
                    case (opcode)
                        OpcHlt:  state_d = StHalt;
                        OpcSto:  wr_ram = 1'b1;
                        OpcLdi: begin
                            sel_a  = SelImm;
                            wr_acc = 1'b1;
                        end
                        OpcAddi, OpcSubi: begin
                            sel_a  = SelAlu;
                            sel_b  = 1'b1;
                            alu_op = (opcode == OpcSubi);
                            wr_acc = 1'b1;
                        end
                        default: rd_ram = mem_op;
                    endcase
                    // Memory operands arrive a cycle late, so those ops finish in EXEC2.
                    if (mem_op) begin
                        state_d = StExec2;
                    end else if (opcode != OpcHlt) begin
                        pc_d    = pc_q + NBITS_O'(1);
                        state_d = StFetch;
                    end
                end
                StExec2: begin
                    sel_a   = (opcode == OpcLd) ? SelMem : SelAlu;
                    alu_op  = (opcode == OpcSub);
                    wr_acc  = 1'b1;
                    pc_d    = pc_q + NBITS_O'(1);
                    state_d = StFetch;
                end
                StHalt: state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            ir_q     <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cycles_q <= cycles_d;
        end
    end

    assign o_PmAddr  = pc_q;
    assign o_DmAddr  = ir_q[NBITS_O-1:0];
    assign o_Operand = ir_q[NBITS_O-1:0];
    assign o_SelA    = sel_a;
    assign o_SelB    = sel_b;
    assign o_WrAcc   = wr_acc;
    assign o_Op      = alu_op;
    assign o_RdRam   = rd_ram;
    assign o_WrRam   = wr_ram;
    assign o_halt    = (state_q == StHalt) & ~i_reset;
    assign o_cycles  = cycles_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: small programs in a synchronous program memory, with
// per-cycle strobe traces compared against hand-derived cycle masks.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] instr;
    logic [10:0] pm_addr;
    logic [10:0] dm_addr;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        rd_ram;
    logic        wr_ram;
    logic        halt;
    logic [31:0] cycles;

    logic [15:0] pm [2048];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_wracc, m_wrram, m_rdram, m_halt, m_op, m_selb;
    logic [10:0] pc_log  [64];
    logic [10:0] dm_log  [64];
    logic [10:0] opd_log [64];
    logic [1:0]  sela_log[64];
    logic [31:0] cyc_log [64];

    control_unit dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_Instruction(instr),
        .o_PmAddr     (pm_addr),
        .o_DmAddr     (dm_addr),
        .o_Operand    (operand),
        .o_SelA       (sel_a),
        .o_SelB       (sel_b),
        .o_WrAcc      (wr_acc),
        .o_Op         (op),
        .o_RdRam      (rd_ram),
        .o_WrRam      (wr_ram),
        .o_halt       (halt),
        .o_cycles     (cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) instr <= pm[pm_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) pm[i] = 16'hF800;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Cycle k is sampled into bit k of the masks; dis[k]=1 drops i_enable during cycle k.
    task automatic run(input int n, input logic [31:0] dis);
        m_wracc = '0; m_wrram = '0; m_rdram = '0;
        m_halt  = '0; m_op    = '0; m_selb  = '0;
        for (int k = 0; k < n; k++) begin
            enable = !dis[k];
            #1;
            m_wracc[k] = wr_acc;
            m_wrram[k] = wr_ram;
            m_rdram[k] = rd_ram;
            m_halt[k]  = halt;
            m_op[k]    = op;
            m_selb[k]  = sel_b;
            pc_log[k]   = pm_addr;
            dm_log[k]   = dm_addr;
            opd_log[k]  = operand;
            sela_log[k] = sel_a;
            cyc_log[k]  = cycles;
            @(posedge clock);
            #1;
        end
        enable = 1'b1;
    endtask

    initial begin
        int          bad;
        logic        any;
        logic [10:0] pc_a, pc_b;
        logic [31:0] cyc_b;

        reset  = 1'b1;
        enable = 1'b0;

        // LDI 5; ADDI 3; STO 7; HLT
        fill_nop();
        pm[0] = 16'h1805; pm[1] = 16'h2803; pm[2] = 16'h0807; pm[3] = 16'h0000;
        do_reset();
        run(16, 32'h0);
        check("t1_reset_pc", pc_log[0], 0);
        check("t1_reset_cycles", cyc_log[0], 0);
        check("t1_wracc", m_wracc, 32'h24);
        check("t1_wrram", m_wrram, 32'h100);
        check("t1_rdram", m_rdram, 32'h0);
        check("t1_halt", m_halt, 32'hF000);
        check("t1_sela_ldi", sela_log[2], 2'b01);
        check("t1_sela_addi", sela_log[5], 2'b10);
        check("t1_selb", m_selb, 32'h20);
        check("t1_op", m_op, 32'h0);
        check("t1_operand", opd_log[2], 5);
        check("t1_dmaddr", dm_log[8], 7);
        check("t1_cycles", cyc_log[15], 12);
        check("t1_pc_halt", pc_log[15], 3);

        // Stay halted for 100 cycles
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (halt !== 1'b1 || wr_acc !== 1'b0 || wr_ram !== 1'b0 || rd_ram !== 1'b0 ||
                pm_addr !== 11'd3 || cycles !== 32'd12) bad++;
            @(posedge clock);
            #1;
        end
        check("t6_halt_hold_bad_cycles", bad, 0);

        // LD 4; SUB 4; HLT
        fill_nop();
        pm[0] = 16'h1004; pm[1] = 16'h3004; pm[2] = 16'h0000;
        do_reset();
        run(16, 32'h0);
        check("t2_rdram", m_rdram, 32'h44);
        check("t2_wracc", m_wracc, 32'h88);
        check("t2_op", m_op, 32'h80);
        check("t2_selb", m_selb, 32'h0);
        check("t2_sela_ld", sela_log[3], 2'b00);
        check("t2_sela_sub", sela_log[7], 2'b10);
        check("t2_dmaddr", dm_log[2], 4);
        check("t2_pc_c4", pc_log[4], 1);
        check("t2_pc_c8", pc_log[8], 2);
        check("t2_halt", m_halt, 32'hF800);
        check("t2_cycles", cyc_log[15], 11);

        // ADDI 3; HLT with i_enable low during cycles 2..4 (EXEC of ADDI)
        fill_nop();
        pm[0] = 16'h2803; pm[1] = 16'h0000;
        do_reset();
        run(12, 32'h1C);
        check("t3_wracc", m_wracc, 32'h20);
        check("t3_mem_strobes", m_wrram | m_rdram, 32'h0);
        check("t3_pc_frozen", pc_log[4], 0);
        check("t3_pc_after", pc_log[6], 1);
        check("t3_cycles_frozen", cyc_log[4], 2);
        check("t3_halt", m_halt, 32'hE00);
        check("t3_cycles_end", cyc_log[11], 6);

        // All-NOP program: PC wraps 2047 -> 0 with no strobes
        fill_nop();
        do_reset();
        any = 1'b0; pc_a = '0; pc_b = '1; cyc_b = '0;
        for (int k = 0; k < 6150; k++) begin
            #1;
            any = any | wr_acc | wr_ram | rd_ram | halt;
            if (k == 6141) pc_a = pm_addr;
            if (k == 6144) begin
                pc_b  = pm_addr;
                cyc_b = cycles;
            end
            @(posedge clock);
            #1;
        end
        check("t4_no_strobes", any, 0);
        check("t4_pc_top", pc_a, 2047);
        check("t4_pc_wrap", pc_b, 0);
        check("t4_cycles", cyc_b, 6144);

        // LDI 1; STO 7; HLT with reset asserted during EXEC of STO
        fill_nop();
        pm[0] = 16'h1801; pm[1] = 16'h0807; pm[2] = 16'h0000;
        do_reset();
        run(5, 32'h0);
        #1;
        check("t5_wrram_pre", wr_ram, 1);
        reset = 1'b1;
        #1;
        check("t5_wrram_in_reset", wr_ram, 0);
        check("t5_wracc_in_reset", wr_acc, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run(12, 32'h0);
        check("t5_pc_after", pc_log[0], 0);
        check("t5_cycles_after", cyc_log[0], 0);
        check("t5_halt_after", m_halt[0], 0);
        check("t5_wracc_rerun", m_wracc, 32'h4);
        check("t5_wrram_rerun", m_wrram, 32'h20);
        check("t5_halt_rerun", m_halt, 32'hE00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
